// File: rtl/key_scan_sequencer.sv
// Key matrix scanner: walks a 4-to-16 decoder select and samples one active-low sense return.
// A debounced press is reported once through a valid/ready handshake, then held off until release.
module key_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned DEBOUNCE_COUNT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic       sense_n,
  output logic       sel_en_n,
  output logic [3:0] sel_idx,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DebMax     = DW'(DEBOUNCE_COUNT);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StSample,
    StDebounce,
    StReport,
    StRelease
  } state_e;

  state_e        state_q;
  logic [SW-1:0] settle_cnt_q;
  logic [DW-1:0] deb_cnt_q;
  logic [DW-1:0] rel_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sel_en_n     <= 1'b1;
      sel_idx      <= 4'd0;
      key_valid    <= 1'b0;
      key_code     <= 4'd0;
      settle_cnt_q <= '0;
      deb_cnt_q    <= '0;
      rel_cnt_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (scan_en) begin
            state_q      <= StSettle;
            sel_en_n     <= 1'b0;
            settle_cnt_q <= '0;
          end
        end
        StSettle: begin
          if (!scan_en) begin
            state_q  <= StIdle;
            sel_en_n <= 1'b1;
          end else if (settle_cnt_q == SettleLast) begin
            state_q <= StSample;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        StSample: begin
          if (!scan_en) begin
            state_q  <= StIdle;
            sel_en_n <= 1'b1;
          end else if (!sense_n) begin
            deb_cnt_q <= DW'(1);
            if (DEBOUNCE_COUNT == 1) begin
              state_q   <= StReport;
              key_valid <= 1'b1;
              key_code  <= sel_idx;
            end else begin
              state_q <= StDebounce;
            end
          end else begin
            sel_idx      <= sel_idx + 4'd1;
            settle_cnt_q <= '0;
            state_q      <= StSettle;
          end
        end
        StDebounce: begin
          if (!scan_en) begin
            state_q  <= StIdle;
            sel_en_n <= 1'b1;
          end else if (!sense_n) begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
            if (deb_cnt_q + 1'b1 == DebMax) begin
              state_q   <= StReport;
              key_valid <= 1'b1;
              key_code  <= sel_idx;
            end
          end else begin
            sel_idx      <= sel_idx + 4'd1;
            settle_cnt_q <= '0;
            state_q      <= StSettle;
          end
        end
        StReport: begin
          if (key_ready) begin
            key_valid <= 1'b0;
            rel_cnt_q <= '0;
            state_q   <= StRelease;
          end
        end
        StRelease: begin
          // Line stays selected so the held key is watched until it reads high long enough.
          if (!sense_n) begin
            rel_cnt_q <= '0;
          end else if (rel_cnt_q + 1'b1 == DebMax) begin
            rel_cnt_q    <= '0;
            sel_idx      <= sel_idx + 4'd1;
            settle_cnt_q <= '0;
            if (scan_en) begin
              state_q <= StSettle;
            end else begin
              state_q  <= StIdle;
              sel_en_n <= 1'b1;
            end
          end else begin
            rel_cnt_q <= rel_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          sel_en_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_scan_sequencer.sv
// Bench for key_scan_sequencer: a keypad model drives sense_n, an abstract scan model predicts
// every output each cycle, and directed scenarios pin specific values.
module tb_key_scan_sequencer;

  localparam int SC = 2;
  localparam int DC = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic        key_ready = 1'b0;
  logic [15:0] pressed = '0;
  logic        sense_n;
  logic        sel_en_n;
  logic [3:0]  sel_idx;
  logic        key_valid;
  logic [3:0]  key_code;

  int n_checks = 0;
  int n_fail = 0;

  key_scan_sequencer #(
    .SETTLE_CYCLES (SC),
    .DEBOUNCE_COUNT(DC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_en  (scan_en),
    .sense_n  (sense_n),
    .sel_en_n (sel_en_n),
    .sel_idx  (sel_idx),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready)
  );

  always #5 clk = ~clk;

  // Keypad: only the selected line can pull the return low.
  assign sense_n = sel_en_n ? 1'b1 : ~pressed[sel_idx];

  // Scan model: dwell = cycles spent on the current line (SC means sampling), lows/highs are
  // run lengths of the sensed level, pending = report outstanding, locked = awaiting release.
  bit m_active, m_pending, m_locked;
  int m_idx, m_dwell, m_lows, m_highs, m_code;
  bit n_active, n_pending, n_locked, line_low;
  int n_idx, n_dwell, n_lows, n_highs, n_code;

  always_comb begin
    n_active  = m_active;
    n_pending = m_pending;
    n_locked  = m_locked;
    n_idx     = m_idx;
    n_dwell   = m_dwell;
    n_lows    = m_lows;
    n_highs   = m_highs;
    n_code    = m_code;
    line_low  = m_active && pressed[m_idx[3:0]];
    if (m_pending) begin
      if (key_ready) begin
        n_pending = 1'b0;
        n_locked  = 1'b1;
        n_highs   = 0;
      end
    end else if (m_locked) begin
      n_highs = line_low ? 0 : m_highs + 1;
      if (n_highs == DC) begin
        n_locked = 1'b0;
        n_highs  = 0;
        n_idx    = (m_idx + 1) % 16;
        n_dwell  = 0;
        n_active = scan_en;
      end
    end else if (!m_active) begin
      if (scan_en) begin
        n_active = 1'b1;
        n_dwell  = 0;
        n_lows   = 0;
      end
    end else if (!scan_en) begin
      n_active = 1'b0;
      n_lows   = 0;
    end else if (m_dwell < SC) begin
      n_dwell = m_dwell + 1;
    end else if (line_low) begin
      n_lows = m_lows + 1;
      if (n_lows == DC) begin
        n_pending = 1'b1;
        n_code    = m_idx;
        n_lows    = 0;
      end
    end else begin
      n_lows  = 0;
      n_idx   = (m_idx + 1) % 16;
      n_dwell = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active  <= 1'b0;
      m_pending <= 1'b0;
      m_locked  <= 1'b0;
      m_idx     <= 0;
      m_dwell   <= 0;
      m_lows    <= 0;
      m_highs   <= 0;
      m_code    <= 0;
    end else begin
      m_active  <= n_active;
      m_pending <= n_pending;
      m_locked  <= n_locked;
      m_idx     <= n_idx;
      m_dwell   <= n_dwell;
      m_lows    <= n_lows;
      m_highs   <= n_highs;
      m_code    <= n_code;
    end
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_sel_en_n", 32'(sel_en_n), 32'(!m_active));
      check("model_sel_idx", 32'(sel_idx), m_idx);
      check("model_key_valid", 32'(key_valid), 32'(m_pending));
      check("model_key_code", 32'(key_code), m_code);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idx(input int idx, input int maxc, input string name);
    int n = 0;
    while (!(sel_idx == 4'(idx) && !sel_en_n) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles, sel_idx=%0d, required %0d", name, n, sel_idx,
               idx);
    end
  endtask

  task automatic wait_valid(input int maxc, input string name);
    int n = 0;
    while (!key_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles, key_valid=0, required 1", name, n);
    end
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_sel_en_n", 32'(sel_en_n), 1);
    check("rst_sel_idx", 32'(sel_idx), 0);
    check("rst_key_valid", 32'(key_valid), 0);
    check("rst_key_code", 32'(key_code), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: idle sweep, one line every SC+1 cycles, wrap 15->0
    scan_en = 1'b1;
    cycles(1);
    check("sweep_start_en_n", 32'(sel_en_n), 0);
    check("sweep_start_idx", 32'(sel_idx), 0);
    cycles(45);
    check("sweep_idx15", 32'(sel_idx), 15);
    cycles(3);
    check("sweep_wrap_idx0", 32'(sel_idx), 0);
    check("sweep_no_valid", 32'(key_valid), 0);

    // 2: line 5 held, single one-cycle report, no repeat while held
    pressed[5] = 1'b1;
    key_ready  = 1'b1;
    wait_valid(100, "t2_valid");
    check("t2_code", 32'(key_code), 5);
    cycles(1);
    check("t2_pulse_end", 32'(key_valid), 0);
    cycles(30);
    check("t2_no_repeat", 32'(key_valid), 0);
    check("t2_held_idx", 32'(sel_idx), 5);
    pressed[5] = 1'b0;
    wait_idx(6, 10, "t2_resume");

    // 3: line 9 low for two samples only
    pressed[9] = 1'b1;
    wait_idx(9, 100, "t3_reach9");
    cycles(4);
    pressed[9] = 1'b0;
    cycles(1);
    check("t3_no_valid", 32'(key_valid), 0);
    check("t3_next_idx", 32'(sel_idx), 10);

    // 4: line 3 with consumer stalled for 20 cycles
    key_ready  = 1'b0;
    pressed[3] = 1'b1;
    wait_valid(100, "t4_valid");
    check("t4_code", 32'(key_code), 3);
    for (int i = 1; i < 20; i++) begin
      cycles(1);
      check("t4_hold_valid", 32'(key_valid), 1);
      check("t4_hold_code", 32'(key_code), 3);
    end
    key_ready = 1'b1;
    cycles(1);
    check("t4_accept", 32'(key_valid), 0);
    pressed[3] = 1'b0;

    // 5: lines 2 and 12 together, scan order decides
    wait_idx(13, 100, "t5_reach13");
    pressed[2]  = 1'b1;
    pressed[12] = 1'b1;
    wait_valid(60, "t5_first");
    check("t5_first_code", 32'(key_code), 2);
    cycles(10);
    check("t5_blocked", 32'(key_valid), 0);
    pressed[2] = 1'b0;
    wait_valid(60, "t5_second");
    check("t5_second_code", 32'(key_code), 12);
    pressed[12] = 1'b0;

    // 6a: reset mid-debounce
    pressed[15] = 1'b1;
    wait_idx(15, 60, "t6_reach15");
    cycles(3);
    #2 rst_n = 1'b0;
    #1;
    check("t6a_en_n", 32'(sel_en_n), 1);
    check("t6a_idx", 32'(sel_idx), 0);
    check("t6a_valid", 32'(key_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6b: reset mid-report, no replay afterwards
    key_ready = 1'b0;
    wait_valid(100, "t6b_valid");
    check("t6b_code", 32'(key_code), 15);
    #2 rst_n = 1'b0;
    #1;
    check("t6b_en_n", 32'(sel_en_n), 1);
    check("t6b_idx", 32'(sel_idx), 0);
    check("t6b_valid", 32'(key_valid), 0);
    @(negedge clk);
    rst_n       = 1'b1;
    pressed[15] = 1'b0;
    key_ready   = 1'b1;
    cycles(60);
    check("t6b_no_replay", 32'(key_valid), 0);

    // 6c: scan_en dropped in SETTLE, resume at held index
    wait_idx(4, 100, "t6c_reach4");
    scan_en = 1'b0;
    cycles(1);
    check("t6c_idle_en_n", 32'(sel_en_n), 1);
    check("t6c_idle_idx", 32'(sel_idx), 4);
    cycles(5);
    check("t6c_still_idx", 32'(sel_idx), 4);
    scan_en = 1'b1;
    cycles(1);
    check("t6c_resume_en_n", 32'(sel_en_n), 0);
    check("t6c_resume_idx", 32'(sel_idx), 4);
    cycles(3);
    check("t6c_next_idx", 32'(sel_idx), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
